// File: rtl/pipelined_control_unit_if.sv
// Decode-to-Execute control bundle between the hazard/pipeline logic and pipelined_control_unit.
interface pipelined_control_unit_if;
    logic       valid_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       stall_e;
    logic       flush_e;
    logic [2:0] ImmSrcD;
    logic       RegWriteE;
    logic [1:0] ResultSrcE;
    logic       ALUsrcE;
    logic       MemWriteE;
    logic       BranchE;
    logic       JumpE;
    logic       jalrE;
    logic       luiE;
    logic [3:0] ALUControlE;
    logic [2:0] R_sizeE;
    logic [2:0] DMem_sizeE;
    logic       load_extend_sE;
    logic [2:0] md_opE;
    logic       md_start;
    logic       md_done;
    logic       md_stall;
    logic       illegalE;

    modport master (
        output valid_d, opcode, funct3, funct7, stall_e, flush_e,
        input  ImmSrcD, RegWriteE, ResultSrcE, ALUsrcE, MemWriteE, BranchE, JumpE, jalrE, luiE,
               ALUControlE, R_sizeE, DMem_sizeE, load_extend_sE, md_opE, md_start, md_done,
               md_stall, illegalE
    );

    modport slave (
        input  valid_d, opcode, funct3, funct7, stall_e, flush_e,
        output ImmSrcD, RegWriteE, ResultSrcE, ALUsrcE, MemWriteE, BranchE, JumpE, jalrE, luiE,
               ALUControlE, R_sizeE, DMem_sizeE, load_extend_sE, md_opE, md_start, md_done,
               md_stall, illegalE
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// RV32 Decode-stage control with registered D->E controls and multi-cycle M-op sequencing.
// Define M_EXT_EN to decode the M extension and build the latency FSM.
module pipelined_control_unit #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned CNT_W      = 6
) (
    input logic                     clk,
    input logic                     rst,
    pipelined_control_unit_if.slave bus
);
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] F7Mext   = 7'b0000001;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSlt  = 4'b0101;
    localparam logic [3:0] AluSltu = 4'b0110;
    localparam logic [3:0] AluSll  = 4'b0111;
    localparam logic [3:0] AluSrl  = 4'b1000;
    localparam logic [3:0] AluSra  = 4'b1001;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    localparam int unsigned MaxLat = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       alu_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       lui;
        logic [3:0] alu_control;
        logic [2:0] r_size;
        logic [2:0] dmem_size;
        logic       load_ext_s;
        logic [2:0] md_op;
        logic       illegal;
    } ctrl_t;

    ctrl_t      dec;
    ctrl_t      e_q, e_d;
    logic       hold_e;
    logic [2:0] imm_src;

    if (MUL_CYCLES < 1 || DIV_CYCLES < 1 || (64'd1 << CNT_W) <= 64'(MaxLat)) begin : g_bad_cfg
        $error("pipelined_control_unit: latency does not fit the counter");
    end

    // alt selects SUB on funct3=000 and SRA on funct3=101; ignored elsewhere.
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    always_comb begin
        case (bus.opcode)
            OpStore:        imm_src = ImmS;
            OpBranch:       imm_src = ImmB;
            OpJal:          imm_src = ImmJ;
            OpLui, OpAuipc: imm_src = ImmU;
            default:        imm_src = ImmI;
        endcase
    end

    always_comb begin
        dec = '0;
        if (bus.valid_d) begin
            case (bus.opcode)
                OpR: begin
                    if (bus.funct7 == F7Mext) begin
`ifdef M_EXT_EN
                        dec.reg_write = 1'b1;
                        dec.md_op     = bus.funct3;
`else
                        dec.illegal   = 1'b1;
`endif
                    end else begin
                        dec.reg_write   = 1'b1;
                        dec.alu_control = alu_sel(bus.funct3, bus.funct7[5]);
                    end
                end
                OpI: begin
                    dec.reg_write   = 1'b1;
                    dec.alu_src     = 1'b1;
                    dec.alu_control = alu_sel(bus.funct3, (bus.funct3 == 3'b101) && bus.funct7[5]);
                end
                OpLoad: begin
                    dec.reg_write  = 1'b1;
                    dec.alu_src    = 1'b1;
                    dec.result_src = 2'b01;
                    dec.r_size     = bus.funct3;
                    dec.load_ext_s = (bus.funct3[2:1] == 2'b00);
                end
                OpStore: begin
                    dec.mem_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.dmem_size = bus.funct3;
                end
                OpBranch: begin
                    dec.branch      = 1'b1;
                    dec.alu_control = AluSub;
                end
                OpJal, OpJalr: begin
                    dec.reg_write  = 1'b1;
                    dec.jump       = 1'b1;
                    dec.alu_src    = 1'b1;
                    dec.result_src = 2'b10;
                    dec.jalr       = (bus.opcode == OpJalr);
                end
                OpLui, OpAuipc: begin
                    dec.reg_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.lui       = (bus.opcode == OpLui);
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

`ifdef M_EXT_EN
    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_start_q, md_start_d;
    logic             md_stall, md_done;
    logic             dec_m, capture_m;

    assign dec_m     = bus.valid_d && (bus.opcode == OpR) && (bus.funct7 == F7Mext);
    assign md_stall  = (state_q == StBusy);
    assign md_done   = md_stall && (cnt_q == '0) && !bus.flush_e && !rst;
    // The last BUSY cycle releases E so a following instruction enters without a gap.
    assign hold_e    = bus.stall_e || (md_stall && !md_done);
    assign capture_m = dec_m && !bus.flush_e && !hold_e;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        md_start_d = 1'b0;
        if (state_q == StBusy) begin
            if (bus.flush_e) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else if (cnt_q == '0) begin
                state_d = StIdle;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        if (capture_m) begin
            state_d    = StBusy;
            cnt_d      = bus.funct3[2] ? DivLoad : MulLoad;
            md_start_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            md_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            md_start_q <= md_start_d;
        end
    end

    assign bus.md_start = md_start_q;
    assign bus.md_done  = md_done;
    assign bus.md_stall = md_stall;
    assign bus.md_opE   = e_q.md_op;
`else
    assign hold_e       = bus.stall_e;
    assign bus.md_start = 1'b0;
    assign bus.md_done  = 1'b0;
    assign bus.md_stall = 1'b0;
    assign bus.md_opE   = 3'b000;
`endif

    always_comb begin
        e_d = e_q;
        if (bus.flush_e) begin
            e_d = '0;
        end else if (!hold_e) begin
            e_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    assign bus.ImmSrcD        = imm_src;
    assign bus.RegWriteE      = e_q.reg_write;
    assign bus.ResultSrcE     = e_q.result_src;
    assign bus.ALUsrcE        = e_q.alu_src;
    assign bus.MemWriteE      = e_q.mem_write;
    assign bus.BranchE        = e_q.branch;
    assign bus.JumpE          = e_q.jump;
    assign bus.jalrE          = e_q.jalr;
    assign bus.luiE           = e_q.lui;
    assign bus.ALUControlE    = e_q.alu_control;
    assign bus.R_sizeE        = e_q.r_size;
    assign bus.DMem_sizeE     = e_q.dmem_size;
    assign bus.load_extend_sE = e_q.load_ext_s;
    assign bus.illegalE       = e_q.illegal;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: directed scenarios plus a randomized run
// against an instruction-level reference model.
module tb_pipelined_control_unit;
    localparam int unsigned MulCycles = 2;
    localparam int unsigned DivCycles = 33;
    localparam logic [6:0]  OpR       = 7'b0110011;
    localparam logic [6:0]  F7M       = 7'b0000001;
`ifdef M_EXT_EN
    localparam bit MExt = 1'b1;
`else
    localparam bit MExt = 1'b0;
`endif

    typedef struct packed {
        logic       rw;
        logic [1:0] rsrc;
        logic       asrc;
        logic       mw;
        logic       br;
        logic       jmp;
        logic       jalr;
        logic       lui;
        logic [3:0] alu;
        logic [2:0] rsize;
        logic [2:0] dsize;
        logic       lext;
        logic [2:0] mdop;
        logic       ill;
    } ctl_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_control_unit_if bus ();

    pipelined_control_unit #(
        .MUL_CYCLES(MulCycles),
        .DIV_CYCLES(DivCycles),
        .CNT_W     (6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    ctl_t obs;
    assign obs = {bus.RegWriteE, bus.ResultSrcE, bus.ALUsrcE, bus.MemWriteE, bus.BranchE,
                  bus.JumpE, bus.jalrE, bus.luiE, bus.ALUControlE, bus.R_sizeE, bus.DMem_sizeE,
                  bus.load_extend_sE, bus.md_opE, bus.illegalE};

    int n_checks = 0;
    int n_pass   = 0;

    // ALU code per funct3 in mnemonic order ADD SLL SLT SLTU XOR SRL OR AND; SUB/SRA are +1.
    logic [3:0] alu_by_f3 [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    logic [6:0] op_tab [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    // Reference model state: expected E contents and remaining cycles of the M op in E.
    ctl_t exp_e;
    int   busy_left;
    bit   exp_start;

    function automatic bit is_mop(logic v, logic [6:0] op, logic [6:0] f7);
        return MExt && v && op == OpR && f7 == F7M;
    endfunction

    function automatic ctl_t ref_decode(logic v, logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
        ctl_t c = '0;
        if (!v) return c;
        case (op)
            7'b0110011: begin
                if (f7 == F7M) begin
                    if (MExt) begin c.rw = 1; c.mdop = f3; end
                    else c.ill = 1;
                end else begin
                    c.rw  = 1;
                    c.alu = alu_by_f3[f3] + 4'(((f3 == 0) || (f3 == 5)) && f7[5]);
                end
            end
            7'b0010011: begin
                c.rw = 1; c.asrc = 1; c.alu = alu_by_f3[f3] + 4'((f3 == 5) && f7[5]);
            end
            7'b0000011: begin
                c.rw = 1; c.asrc = 1; c.rsrc = 2'b01; c.rsize = f3; c.lext = (f3 <= 3'd1);
            end
            7'b0100011: begin c.mw = 1; c.asrc = 1; c.dsize = f3; end
            7'b1100011: begin c.br = 1; c.alu = 4'd1; end
            7'b1101111: begin c.rw = 1; c.jmp = 1; c.asrc = 1; c.rsrc = 2'b10; end
            7'b1100111: begin c.rw = 1; c.jmp = 1; c.jalr = 1; c.asrc = 1; c.rsrc = 2'b10; end
            7'b0110111: begin c.rw = 1; c.asrc = 1; c.lui = 1; end
            7'b0010111: begin c.rw = 1; c.asrc = 1; end
            default:    c.ill = 1;
        endcase
        return c;
    endfunction

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic st, input logic fl);
        bus.valid_d = v;
        bus.opcode  = op;
        bus.funct3  = f3;
        bus.funct7  = f7;
        bus.stall_e = st;
        bus.flush_e = fl;
        #1;
    endtask

    // One clock edge; the model consumes the inputs that were stable across it.
    task automatic cycle();
        bit hold;
        @(posedge clk);
        hold = bus.stall_e || (busy_left > 1);
        if (rst || bus.flush_e) begin
            exp_e = '0; busy_left = 0; exp_start = 0;
        end else begin
            exp_start = 0;
            if (busy_left > 0) busy_left--;
            if (!hold) begin
                exp_e = ref_decode(bus.valid_d, bus.opcode, bus.funct3, bus.funct7);
                if (is_mop(bus.valid_d, bus.opcode, bus.funct7)) begin
                    busy_left = bus.funct3[2] ? DivCycles : MulCycles;
                    exp_start = 1;
                end
            end
        end
        #1;
    endtask

    function automatic ctl_t add_ctl();
        ctl_t c = '0;
        c.rw = 1;
        return c;
    endfunction

    task automatic test_reset(input bit mid_busy);
        drive(1'b1, OpR, 3'b000, 7'h00, 1'b0, 1'b0);
        cycle();
        if (mid_busy && MExt) begin
            drive(1'b1, OpR, 3'b100, F7M, 1'b0, 1'b0);
            cycle();
            drive(1'b1, OpR, 3'b000, 7'h00, 1'b0, 1'b0);
            cycle();
        end
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== '0) $display("FAIL reset_ctrl: got %h, required 0", obs);
        else n_pass++;
        n_checks++;
        if ({bus.RegWriteE, bus.md_stall, bus.md_start, bus.md_done} !== 4'b0000)
            $display("FAIL reset_md: got rw/stall/start/done %b%b%b%b, required 0000",
                     bus.RegWriteE, bus.md_stall, bus.md_start, bus.md_done);
        else n_pass++;
    endtask

    task automatic test_add_sub();
        drive(1'b1, OpR, 3'b000, 7'b0000000, 1'b0, 1'b0);
        cycle();
        n_checks++;
        if ({bus.ALUControlE, bus.RegWriteE} !== 5'b0000_1)
            $display("FAIL add: got alu %b rw %b, required 0000 1", bus.ALUControlE, bus.RegWriteE);
        else n_pass++;
        drive(1'b1, OpR, 3'b000, 7'b0100000, 1'b0, 1'b0);
        cycle();
        n_checks++;
        if (bus.ALUControlE !== 4'b0001)
            $display("FAIL sub: got alu %b, required 0001", bus.ALUControlE);
        else n_pass++;
    endtask

    task automatic test_load_store();
        drive(1'b1, 7'b0000011, 3'b000, 7'h00, 1'b0, 1'b0);
        cycle();
        n_checks++;
        if ({bus.ResultSrcE, bus.R_sizeE, bus.load_extend_sE} !== 6'b01_000_1)
            $display("FAIL lb: got rsrc %b rsize %b lext %b, required 01 000 1",
                     bus.ResultSrcE, bus.R_sizeE, bus.load_extend_sE);
        else n_pass++;
        drive(1'b1, 7'b0100011, 3'b010, 7'h00, 1'b0, 1'b0);
        cycle();
        n_checks++;
        if ({bus.MemWriteE, bus.DMem_sizeE, bus.RegWriteE} !== 5'b1_010_0)
            $display("FAIL sw: got mw %b dsize %b rw %b, required 1 010 0",
                     bus.MemWriteE, bus.DMem_sizeE, bus.RegWriteE);
        else n_pass++;
    endtask

    task automatic test_illegal();
        drive(1'b1, 7'b1111111, 3'b000, 7'h00, 1'b0, 1'b0);
        cycle();
        n_checks++;
        if ({bus.illegalE, bus.RegWriteE, bus.MemWriteE, bus.BranchE, bus.JumpE,
             bus.ALUControlE} !== 9'b1_0000_0000)
            $display("FAIL illegal_op: got ill %b en %b%b%b%b alu %b, required 1 0000 0000",
                     bus.illegalE, bus.RegWriteE, bus.MemWriteE, bus.BranchE, bus.JumpE,
                     bus.ALUControlE);
        else n_pass++;
        drive(1'b0, OpR, 3'b000, 7'h00, 1'b0, 1'b0);
        cycle();
        n_checks++;
        if (obs !== '0) $display("FAIL invalid_bubble: got %h, required 0", obs);
        else n_pass++;
    endtask

    task automatic test_stall_flush();
        drive(1'b1, OpR, 3'b000, 7'h00, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 7'b0100011, 3'b001, 7'h20, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (obs !== add_ctl()) $display("FAIL stall_hold[%0d]: got %h, required %h",
                                            i, obs, add_ctl());
            else n_pass++;
        end
        drive(1'b1, 7'b0100011, 3'b001, 7'h20, 1'b1, 1'b1);
        cycle();
        n_checks++;
        if (obs !== '0) $display("FAIL stall_flush: got %h, required 0", obs);
        else n_pass++;
        drive(1'b0, OpR, 3'b000, 7'h00, 1'b0, 1'b0);
    endtask

`ifdef M_EXT_EN
    task automatic test_m_ext();
        int stalls = 0, starts = 0, dones = 0, start_at = 0, done_at = 0, low_at = 0;
        // DIV: stall window, start/done positions, and the ADD behind it.
        drive(1'b1, OpR, 3'b100, F7M, 1'b0, 1'b0);
        cycle();
        drive(1'b1, OpR, 3'b000, 7'h00, 1'b0, 1'b0);
        for (int k = 1; k <= 60; k++) begin
            if (!bus.md_stall) begin low_at = k; break; end
            stalls++;
            if (bus.md_start) begin starts++; start_at = k; end
            if (bus.md_done) begin dones++; done_at = k; end
            cycle();
        end
        n_checks++;
        if (stalls != 33 || low_at != 34)
            $display("FAIL div_stall: got %0d cycles (low at %0d), required 33 (low at 34)",
                     stalls, low_at);
        else n_pass++;
        n_checks++;
        if (starts != 1 || start_at != 1 || dones != 1 || done_at != 33)
            $display("FAIL div_pulses: got start %0dx@%0d done %0dx@%0d, required 1x@1 1x@33",
                     starts, start_at, dones, done_at);
        else n_pass++;
        n_checks++;
        if (obs !== add_ctl()) $display("FAIL div_next_add: got %h, required %h", obs, add_ctl());
        else n_pass++;

        // Flush in BUSY cycle 5 of a DIV.
        drive(1'b1, OpR, 3'b101, F7M, 1'b0, 1'b0);
        cycle();
        drive(1'b1, OpR, 3'b000, 7'h00, 1'b0, 1'b0);
        repeat (4) cycle();
        drive(1'b1, OpR, 3'b000, 7'h00, 1'b0, 1'b1);
        cycle();
        drive(1'b1, OpR, 3'b000, 7'h00, 1'b0, 1'b0);
        n_checks++;
        if ({bus.md_stall, bus.md_done} !== 2'b00 || obs !== '0)
            $display("FAIL div_flush: got stall %b done %b ctrl %h, required 0 0 0",
                     bus.md_stall, bus.md_done, obs);
        else n_pass++;
        cycle();
        n_checks++;
        if (bus.md_done !== 1'b0 || obs !== add_ctl())
            $display("FAIL div_flush_after: got done %b ctrl %h, required 0 %h",
                     bus.md_done, obs, add_ctl());
        else n_pass++;

        // Back-to-back MUL then MULH: no idle cycle between them.
        drive(1'b1, OpR, 3'b000, F7M, 1'b0, 1'b0);
        cycle();
        drive(1'b1, OpR, 3'b001, F7M, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            logic [2:0] want;
            case (k)
                1, 3:    want = 3'b110;
                2, 4:    want = 3'b101;
                default: want = 3'b000;
            endcase
            n_checks++;
            if ({bus.md_stall, bus.md_start, bus.md_done} !== want)
                $display("FAIL b2b_md[%0d]: got stall/start/done %b%b%b, required %b", k,
                         bus.md_stall, bus.md_start, bus.md_done, want);
            else n_pass++;
            if (k == 3) begin
                n_checks++;
                if (bus.md_opE !== 3'b001) $display("FAIL b2b_mdop: got %b, required 001",
                                                    bus.md_opE);
                else n_pass++;
                drive(1'b1, OpR, 3'b000, 7'h00, 1'b0, 1'b0);
            end
            cycle();
        end
    endtask
`else
    task automatic test_m_ext();
        drive(1'b1, OpR, 3'b100, F7M, 1'b0, 1'b0);
        cycle();
        n_checks++;
        if ({bus.illegalE, bus.RegWriteE, bus.md_opE} !== 5'b1_0_000)
            $display("FAIL m_disabled: got ill %b rw %b mdop %b, required 1 0 000",
                     bus.illegalE, bus.RegWriteE, bus.md_opE);
        else n_pass++;
        cycle();
        n_checks++;
        if ({bus.md_stall, bus.md_start, bus.md_done} !== 3'b000)
            $display("FAIL m_disabled_md: got %b%b%b, required 000",
                     bus.md_stall, bus.md_start, bus.md_done);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic       v, st, fl;
        logic [6:0] op, f7;
        logic [2:0] f3;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 9) != 0);
            op = ($urandom_range(0, 10) < 9) ? op_tab[$urandom_range(0, 8)] : 7'($urandom);
            f3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       f7 = 7'b0000000;
                1:       f7 = 7'b0100000;
                2:       f7 = F7M;
                default: f7 = 7'($urandom);
            endcase
            st  = ($urandom_range(0, 6) == 0);
            fl  = ($urandom_range(0, 12) == 0);
            rst = ($urandom_range(0, 60) == 0);
            drive(v, op, f3, f7, st, fl);
            n_checks++;
            if (obs !== exp_e) $display("FAIL rand_ctrl[%0d]: got %h, required %h", i, obs, exp_e);
            else n_pass++;
            n_checks++;
            if ({bus.md_stall, bus.md_start, bus.md_done} !==
                {busy_left > 0, exp_start, busy_left == 1 && !fl && !rst})
                $display("FAIL rand_md[%0d]: got stall/start/done %b%b%b, required %b%b%b", i,
                         bus.md_stall, bus.md_start, bus.md_done, busy_left > 0, exp_start,
                         busy_left == 1 && !fl && !rst);
            else n_pass++;
            cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        exp_e     = '0;
        busy_left = 0;
        exp_start = 0;
        rst       = 1'b1;
        drive(1'b0, 7'h00, 3'b000, 7'h00, 1'b0, 1'b0);
        test_reset(1'b0);
        test_add_sub();
        test_load_store();
        test_illegal();
        test_stall_flush();
        test_m_ext();
        test_reset(1'b1);
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Decode-stage control for the pipelined RV32 core, replacing the purely combinational decoder plus ALU decoder pair.
- Decodes opcode, funct3 and funct7 and registers all Execute-stage control into an internal D→E pipeline register with stall and flush.
- Flags illegal instructions.
- Sequences multi-cycle M-extension operations with a latency counter that raises its own stall request to the hazard unit.

Parameters:
- MUL_CYCLES, 2, Execute-stage cycles a MUL/MULH/MULHSU/MULHU occupies (≥1).
- DIV_CYCLES, 33, Execute-stage cycles a DIV/DIVU/REM/REMU occupies (≥1).
- CNT_W, 6, width of the latency counter; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- valid_d  in  1  Decode holds a real instruction
- opcode  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- stall_e  in  1  hazard unit: hold the E register
- flush_e  in  1  hazard unit: load a bubble into the E register
- ImmSrcD  out  3  combinational immediate select for the Decode-stage extender
- RegWriteE  out  1  register-file write enable (registered)
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUsrcE  out  1  1 = immediate operand
- MemWriteE  out  1  store enable
- BranchE  out  1  conditional branch
- JumpE  out  1  jal or jalr
- jalrE  out  1  jalr
- luiE  out  1  lui
- ALUControlE  out  4  ALU operation code
- R_sizeE  out  3  load size (funct3 of load)
- DMem_sizeE  out  3  store size (funct3 of store)
- load_extend_sE  out  1  sign-extend load (LB, LH)
- md_opE  out  3  M-extension funct3
- md_start  out  1  one-cycle pulse: multiply/divide unit begins
- md_done  out  1  one-cycle pulse: result valid this cycle
- md_stall  out  1  stall request to the hazard unit
- illegalE  out  1  instruction in E is illegal

Behaviour:
- ALUControl encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
  - SUB only for R-type with funct7[5]=1.
  - SRA for funct7[5]=1 on shift-right forms.
  - Loads, stores, jumps, lui and auipc use ADD.
  - Branches use SUB.
- Decoded opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
- Any other opcode, or valid_d=0: bubble. A bubble has all enables (RegWrite, MemWrite, Branch, Jump) = 0 and ALUControl = 0000.
- An unknown opcode with valid_d=1 also sets illegal.
- E register update each rising clk edge, in priority order:
  - rst: all E outputs 0.
  - flush_e: bubble.
  - stall_e or md_stall: hold.
  - otherwise: capture the decode.
- Reset values: every output 0, FSM state IDLE, counter 0.
- FSM states: IDLE, BUSY.
  - IDLE→BUSY on the edge where E captures a valid M op (opcode 0110011, funct7 0000001).
  - On that edge the counter loads LAT−1, where LAT = DIV_CYCLES if funct3[2]=1, else MUL_CYCLES.
  - BUSY: md_stall=1 (combinational from state); the counter decrements each cycle.
  - BUSY with counter==0 → IDLE at the next edge; md_done=1 during that last BUSY cycle.
- md_start: registered, 1 in the first BUSY cycle only.
- Latency: a M op occupies E for exactly LAT cycles, then leaves on the following edge.
- LAT=1: md_start and md_done are both 1 in the same single cycle.
- flush_e while BUSY: state→IDLE, counter→0, E register bubbles, no md_done. flush_e takes priority over counter expiry.
- stall_e while BUSY: the counter still decrements. md_done still fires; afterwards the E register holds on stall_e alone.
- Back-to-back M ops: the second is captured on the edge leaving BUSY and immediately re-enters BUSY. No IDLE cycle.
- rst while BUSY: IDLE next cycle, no md_done.

Optional Feature:
- Macro: M_EXT_EN.
- Defined: M-extension decoded as above. R-type with funct7 0000001 sets RegWrite=1 and ResultSrc=00, and the FSM is present.
- Undefined: funct7 0000001 on opcode 0110011 decodes as illegal with bubble controls. FSM and counter are not generated. md_start, md_done, md_stall and md_opE are tied 0.

Test Plan:
- Reset: assert rst for 2 cycles mid-stream → all outputs 0 the cycle after, including RegWriteE and md_stall.
- ADD vs SUB: ADD (0110011/000/0000000) → next cycle ALUControlE=0000, RegWriteE=1. SUB (funct7=0100000) → ALUControlE=0001.
- LB then SW:
  - LB (0000011/000) → ResultSrcE=01, R_sizeE=000, load_extend_sE=1.
  - SW (0100011/010) → MemWriteE=1, DMem_sizeE=010, RegWriteE=0.
- DIV with DIV_CYCLES=33 (M_EXT_EN):
  - md_stall high for exactly 33 cycles.
  - md_start in cycle 1, md_done in cycle 33.
  - The following ADD enters E on the next edge.
- flush_e at BUSY cycle 5 of a DIV → md_stall low the next cycle, no md_done, E outputs bubble.
- Illegal and stall/flush:
  - Opcode 1111111 with valid_d=1 → illegalE=1, all enables 0.
  - stall_e held 3 cycles with a new opcode at input → E outputs unchanged.
  - flush_e and stall_e together → bubble.
